// File: rtl/mpram_rr.sv
// -----------------------------------------------------------------------------
// mpram_rr -- multi-port, byte-masked, single-port RAM with round-robin access
//
// NPORTS requesters share one single-port storage array. A round-robin arbiter
// grants at most one access per cycle. Every granted access, read or write,
// returns a one-hot-tagged response after a fixed latency of 1 cycle
// (EN_PIPE=0) or 2 cycles (EN_PIPE=1). Write responses carry the word as it was
// before the write.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   req_valid_i   [NPORTS]        per-port request valid
//   req_ready_o   [NPORTS]        one-hot grant, combinational
//   req_we_i      [NPORTS]        per-port write enable
//   req_addr_i    [NPORTS*ADDRW]  packed byte addresses, port p at [p*ADDRW +: ADDRW]
//   req_data_i    [NPORTS*DATAW]  packed write data
//   req_mask_i    [NPORTS*MASKW]  packed byte enables
//   resp_valid_o  [NPORTS]        one-hot completion tag
//   resp_data_o   [DATAW]         shared read data, qualified by resp_valid_o
// -----------------------------------------------------------------------------
module mpram_rr #(
  parameter int unsigned SIZE      = 1024,
  parameter int unsigned DATAW     = 32,
  parameter int unsigned NPORTS    = 2,
  parameter int unsigned EN_PIPE   = 1,
  parameter string       INIT_FILE = "",
  localparam int unsigned MASKW    = DATAW / 8,
  localparam int unsigned DEPTH    = SIZE / MASKW,
  localparam int unsigned ADDRW    = $clog2(SIZE)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NPORTS-1:0]         req_valid_i,
  output logic [NPORTS-1:0]         req_ready_o,
  input  logic [NPORTS-1:0]         req_we_i,
  input  logic [NPORTS*ADDRW-1:0]   req_addr_i,
  input  logic [NPORTS*DATAW-1:0]   req_data_i,
  input  logic [NPORTS*MASKW-1:0]   req_mask_i,
  output logic [NPORTS-1:0]         resp_valid_o,
  output logic [DATAW-1:0]          resp_data_o
);

  localparam int unsigned OFFW  = $clog2(MASKW);
  localparam int unsigned IDXW  = ADDRW - OFFW;
  localparam int unsigned PRIOW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [PRIOW-1:0]  prio_q, prio_d;
  logic [NPORTS-1:0] gnt_oh;
  logic [PRIOW-1:0]  gnt_idx;
  logic              gnt_any;

  // First asserted valid at or after prio_q, searching upward with wrap.
  // No grant at all while in reset, so nothing is written during reset.
  always_comb begin : arb
    int p;
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    p       = 0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      p = int'(prio_q) + i;
      if (p >= int'(NPORTS)) p = p - int'(NPORTS);
      if (!gnt_any && !rst_i && req_valid_i[p]) begin
        gnt_any   = 1'b1;
        gnt_oh[p] = 1'b1;
        gnt_idx   = PRIOW'(p);
      end
    end
  end

  assign req_ready_o = gnt_oh;

  // The port after the winner becomes highest priority; no grant, no move.
  always_comb begin
    prio_d = prio_q;
    if (gnt_any) begin
      if (gnt_idx == PRIOW'(NPORTS - 1)) prio_d = '0;
      else                               prio_d = gnt_idx + PRIOW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= '0;
    else       prio_q <= prio_d;
  end

  // ---------------------------------------------------------------------------
  // Granted request payload
  // ---------------------------------------------------------------------------
  logic             sel_we;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_data;
  logic [MASKW-1:0] sel_mask;
  logic [IDXW-1:0]  sel_idx;
  logic             unused_addr_bits;

  assign sel_we   = req_we_i[gnt_idx];
  assign sel_addr = req_addr_i[gnt_idx*ADDRW +: ADDRW];
  assign sel_data = req_data_i[gnt_idx*DATAW +: DATAW];
  assign sel_mask = req_mask_i[gnt_idx*MASKW +: MASKW];
  // Byte-offset bits are dropped: the word is addressed, no misalignment check.
  assign sel_idx  = sel_addr[ADDRW-1:OFFW];
  assign unused_addr_bits = ^sel_addr;

  // ---------------------------------------------------------------------------
  // Storage: one index, one write per cycle, synchronous read
  // ---------------------------------------------------------------------------
  logic [DATAW-1:0] mem_q [DEPTH];
  logic [DATAW-1:0] rd_q;

  // NOTE: the array has no reset branch; resetting it would prevent mapping
  // onto a RAM macro, and contents must survive reset anyway.
  always_ff @(posedge clk_i) begin
    if (gnt_any && sel_we) begin
      for (int b = 0; b < int'(MASKW); b++) begin
        if (sel_mask[b]) mem_q[sel_idx][b*8 +: 8] <= sel_data[b*8 +: 8];
      end
    end
  end

  // Read on every grant, writes included. Sampling the array at the same edge
  // as the write yields the pre-write word. Holds when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_q <= '0;
    else if (gnt_any) rd_q <= mem_q[sel_idx];
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  logic [NPORTS-1:0] v1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) v1_q <= '0;
    else       v1_q <= gnt_oh;
  end

  generate
    if (EN_PIPE != 0) begin : g_pipe
      logic [NPORTS-1:0] v2_q;
      logic [DATAW-1:0]  d2_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v2_q <= '0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (|v1_q) d2_q <= rd_q;
        end
      end

      assign resp_valid_o = v2_q;
      assign resp_data_o  = d2_q;
    end else begin : g_nopipe
      assign resp_valid_o = v1_q;
      assign resp_data_o  = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_mpram_rr.sv
// -----------------------------------------------------------------------------
// tb_mpram_rr -- directed, table-driven bench for mpram_rr
// Configuration: SIZE=1024, DATAW=32, NPORTS=3, EN_PIPE=1.
// Every port is driven with the same payload each step; only the valid mask
// differs, so the granted port decides which access happens.
// Each table row is one cycle: inputs applied after the falling edge, outputs
// compared 1 ns later. A response for a row accepted at its rising edge is
// observed two rows later.
// -----------------------------------------------------------------------------
module tb_mpram_rr;

  localparam int unsigned SIZE   = 1024;
  localparam int unsigned DATAW  = 32;
  localparam int unsigned NPORTS = 3;
  localparam int unsigned MASKW  = DATAW / 8;
  localparam int unsigned ADDRW  = $clog2(SIZE);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NPORTS-1:0]       req_valid;
  logic [NPORTS-1:0]       req_ready;
  logic [NPORTS-1:0]       req_we;
  logic [NPORTS*ADDRW-1:0] req_addr;
  logic [NPORTS*DATAW-1:0] req_data;
  logic [NPORTS*MASKW-1:0] req_mask;
  logic [NPORTS-1:0]       resp_valid;
  logic [DATAW-1:0]        resp_data;

  int n_checks = 0;
  int n_errors = 0;

  mpram_rr #(
    .SIZE     (SIZE),
    .DATAW    (DATAW),
    .NPORTS   (NPORTS),
    .EN_PIPE  (1),
    .INIT_FILE("")
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_mask_i  (req_mask),
    .resp_valid_o(resp_valid),
    .resp_data_o (resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_rv;
    logic [31:0] exp_rd;
    logic        chk_rd;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic we, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    req_valid = v;
    req_we    = {NPORTS{we}};
    req_addr  = {NPORTS{a}};
    req_data  = {NPORTS{d}};
    req_mask  = {NPORTS{m}};
  endtask

  initial begin
    // valid we addr data mask | exp_ready exp_rv exp_rd chk_rd
    // Basic write / read at 0x10, ack carries the pre-write word
    vq.push_back('{3'b001, 1'b1, 10'h010, 32'h01020304, 4'hF, 3'b001, 3'b000, 32'h00000000, 1'b1}); // s0
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b000, 32'h00000000, 1'b1}); // s1
    vq.push_back('{3'b001, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 3'b001, 3'b001, 32'h0,        1'b0}); // s2
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b000, 32'h0,        1'b0}); // s3
    vq.push_back('{3'b001, 1'b0, 10'h010, 32'h0,        4'h0, 3'b001, 3'b001, 32'h01020304, 1'b1}); // s4
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b000, 32'h01020304, 1'b1}); // s5 hold
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b001, 32'hDEADBEEF, 1'b1}); // s6
    // Byte mask on 0x20 from port 1 (also moves prio to 2)
    vq.push_back('{3'b010, 1'b1, 10'h020, 32'h11223344, 4'hF, 3'b010, 3'b000, 32'hDEADBEEF, 1'b1}); // s7
    vq.push_back('{3'b010, 1'b1, 10'h020, 32'hAABBCCDD, 4'h5, 3'b010, 3'b000, 32'hDEADBEEF, 1'b1}); // s8
    vq.push_back('{3'b010, 1'b0, 10'h020, 32'h0,        4'h0, 3'b010, 3'b010, 32'h0,        1'b0}); // s9
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b010, 32'h11223344, 1'b1}); // s10
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b010, 32'h11BB33DD, 1'b1}); // s11
    // Fairness: prio=2, ports 0 and 2 together -> 2 then 0
    vq.push_back('{3'b101, 1'b0, 10'h010, 32'h0,        4'h0, 3'b100, 3'b000, 32'h11BB33DD, 1'b1}); // s12
    vq.push_back('{3'b101, 1'b0, 10'h010, 32'h0,        4'h0, 3'b001, 3'b000, 32'h11BB33DD, 1'b1}); // s13
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b100, 32'hDEADBEEF, 1'b1}); // s14
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b001, 32'hDEADBEEF, 1'b1}); // s15
    // Port 2 alone returns prio to 0, then six cycles of full contention
    vq.push_back('{3'b100, 1'b0, 10'h020, 32'h0,        4'h0, 3'b100, 3'b000, 32'hDEADBEEF, 1'b1}); // s16
    vq.push_back('{3'b111, 1'b0, 10'h020, 32'h0,        4'h0, 3'b001, 3'b000, 32'h0,        1'b0}); // s17
    vq.push_back('{3'b111, 1'b0, 10'h020, 32'h0,        4'h0, 3'b010, 3'b100, 32'h11BB33DD, 1'b1}); // s18
    vq.push_back('{3'b111, 1'b0, 10'h020, 32'h0,        4'h0, 3'b100, 3'b001, 32'h11BB33DD, 1'b1}); // s19
    vq.push_back('{3'b111, 1'b0, 10'h020, 32'h0,        4'h0, 3'b001, 3'b010, 32'h11BB33DD, 1'b1}); // s20
    vq.push_back('{3'b111, 1'b0, 10'h020, 32'h0,        4'h0, 3'b010, 3'b100, 32'h11BB33DD, 1'b1}); // s21
    vq.push_back('{3'b111, 1'b0, 10'h020, 32'h0,        4'h0, 3'b100, 3'b001, 32'h11BB33DD, 1'b1}); // s22
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b010, 32'h11BB33DD, 1'b1}); // s23
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b100, 32'h11BB33DD, 1'b1}); // s24
    // Read-after-write back to back: port 0 writes 5 at 0x0, port 1 reads 0x0
    vq.push_back('{3'b001, 1'b1, 10'h000, 32'h00000005, 4'hF, 3'b001, 3'b000, 32'h11BB33DD, 1'b1}); // s25
    vq.push_back('{3'b010, 1'b0, 10'h000, 32'h0,        4'h0, 3'b010, 3'b000, 32'h11BB33DD, 1'b1}); // s26
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b001, 32'h0,        1'b0}); // s27
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b010, 32'h00000005, 1'b1}); // s28
    // Zero-mask write is a no-op but still acks with the current word
    vq.push_back('{3'b001, 1'b1, 10'h000, 32'hFFFFFFFF, 4'h0, 3'b001, 3'b000, 32'h00000005, 1'b1}); // s29
    vq.push_back('{3'b001, 1'b0, 10'h000, 32'h0,        4'h0, 3'b001, 3'b000, 32'h00000005, 1'b1}); // s30
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b001, 32'h00000005, 1'b1}); // s31
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b001, 32'h00000005, 1'b1}); // s32
    // Byte-offset bits ignored: 0x13 reads the word at 0x10
    vq.push_back('{3'b010, 1'b0, 10'h013, 32'h0,        4'h0, 3'b010, 3'b000, 32'h00000005, 1'b1}); // s33
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b000, 32'h00000005, 1'b1}); // s34
    vq.push_back('{3'b000, 1'b0, 10'h000, 32'h0,        4'h0, 3'b000, 3'b010, 32'hDEADBEEF, 1'b1}); // s35

    // Reset with all ports requesting writes: no grant may be issued
    rst = 1'b1;
    drive(3'b111, 1'b1, 10'h010, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    #1;
    check("reset ready", 32'(req_ready), 32'h0);
    check("reset resp_valid", 32'(resp_valid), 32'h0);
    check("reset resp_data", resp_data, 32'h0);
    rst = 1'b0;
    drive(3'b000, 1'b0, 10'h000, 32'h0, 4'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].valid, vq[i].we, vq[i].addr, vq[i].data, vq[i].mask);
      #1;
      check($sformatf("s%0d ready", i), 32'(req_ready), 32'(vq[i].exp_ready));
      check($sformatf("s%0d resp_valid", i), 32'(resp_valid), 32'(vq[i].exp_rv));
      if (vq[i].chk_rd) check($sformatf("s%0d resp_data", i), resp_data, vq[i].exp_rd);
    end

    // Reset mid-flight: accept a read (prio is 2 here, port 0 wins, prio -> 1)
    @(negedge clk);
    drive(3'b001, 1'b0, 10'h010, 32'h0, 4'h0);
    #1;
    check("mid accept ready", 32'(req_ready), 32'h1);
    // Next cycle: reset, with a write to 0x10 pending that must not land
    @(negedge clk);
    rst = 1'b1;
    drive(3'b001, 1'b1, 10'h010, 32'h0, 4'hF);
    #1;
    check("mid rst ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 1'b0, 10'h000, 32'h0, 4'h0);
    #1;
    check("mid dropped resp_valid", 32'(resp_valid), 32'h0);
    check("mid resp_data cleared", resp_data, 32'h0);
    @(negedge clk);
    #1;
    check("mid idle resp_valid", 32'(resp_valid), 32'h0);
    // prio back to 0: ports 0 and 2 -> port 0 (prio 1 would pick port 2)
    @(negedge clk);
    drive(3'b101, 1'b0, 10'h010, 32'h0, 4'h0);
    #1;
    check("post rst prio ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    drive(3'b000, 1'b0, 10'h000, 32'h0, 4'h0);
    #1;
    check("post rst latency1", 32'(resp_valid), 32'h0);
    @(negedge clk);
    #1;
    check("post rst resp_valid", 32'(resp_valid), 32'h1);
    check("post rst retained", resp_data, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
